// File: rtl/msg_loader.sv
// ---------------------------------------------------------------------------
// msg_loader
//
// Upstream front end of the hash datapath. Accepts a message byte stream over
// a valid/ready handshake, writes it into the shared byte RAM starting at
// BASE_ADDR, then sequences the pad block and the sha256 core and reports
// completion with a one-cycle done pulse. Single-block messages only
// (at most MAX_LEN bytes, MAX_LEN <= 55).
//
// Optional feature macro: LOADER_WDOG_EN
//   Defined   : PAD and HASH are each guarded by a WDOG_CYCLES watchdog that
//               sets err_timeout and abandons the message back to LOAD.
//   Undefined : no watchdog, err_timeout is tied low, PAD/HASH wait forever.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid, in_data, in_last    message byte stream in
//   in_ready                      loader accepts a byte this cycle
//   memAddr, memData, memWe       RAM write port
//   busOwn                        loader drives the shared addr/data bus
//   dataLen                       message length in bytes, to pad
//   padStart, padFinish           level start / done handshake with pad
//   shaStart, shaFinish           level start / done handshake with sha256
//   busy                          high in every state except LOAD
//   done                          one-cycle pulse on hash completion
//   err_overflow                  sticky, message truncated at MAX_LEN
//   err_timeout                   sticky, watchdog fired
// ---------------------------------------------------------------------------
module msg_loader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int MAX_LEN     = 55,
    parameter int BASE_ADDR   = 0,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memData,
    output logic              memWe,
    output logic              busOwn,
    output logic [7:0]        dataLen,
    output logic              padStart,
    input  logic              padFinish,
    output logic              shaStart,
    input  logic              shaFinish,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    // Reject configurations that cannot fit in one padded 512-bit block.
    generate
        if (MAX_LEN < 1 || MAX_LEN > 55) begin : gBadMaxLen
            $error("msg_loader: MAX_LEN must be in the range 1..55");
        end
        if (WDOG_CYCLES < 1) begin : gBadWdog
            $error("msg_loader: WDOG_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PAD  = 2'd1,
        HASH = 2'd2,
        DONE = 2'd3
    } loaderState_t;

    loaderState_t     state;
    logic [CNT_W-1:0] count;
    logic             handshake;
    logic             finalByte;

    // A byte is taken only in LOAD while ready. The accepted byte closes the
    // message either because it carries in_last or because it fills the
    // last free slot.
    assign handshake = in_valid && in_ready && (state == LOAD);
    assign finalByte = in_last || (count == CNT_W'(MAX_LEN - 1));

`ifdef LOADER_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdogCnt;
    logic            wdogExpired;

    // The counter reads WDOG_CYCLES-1 during the WDOG_CYCLES-th cycle spent
    // in a wait state, so the abort takes effect right after that cycle.
    assign wdogExpired = (wdogCnt == WD_W'(WDOG_CYCLES - 1));
`else
    assign err_timeout = 1'b0;
`endif

    // Main sequencer. All outputs are registered. The write strobe, bus
    // ownership and done pulse default low every cycle and are raised only
    // for the single cycle that needs them. Inside LOAD, in_ready low means
    // the final byte was taken last cycle and its write is on the bus now,
    // so the move to PAD happens after that write has completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            count        <= '0;
            in_ready     <= 1'b1;
            memAddr      <= ADDR_W'(BASE_ADDR);
            memData      <= '0;
            memWe        <= 1'b0;
            busOwn       <= 1'b0;
            dataLen      <= '0;
            padStart     <= 1'b0;
            shaStart     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
`ifdef LOADER_WDOG_EN
            err_timeout  <= 1'b0;
            wdogCnt      <= '0;
`endif
        end else begin
            memWe  <= 1'b0;
            busOwn <= 1'b0;
            done   <= 1'b0;

            case (state)
                LOAD: begin
                    if (handshake) begin
                        memAddr <= ADDR_W'(BASE_ADDR) + ADDR_W'(count);
                        memData <= in_data;
                        memWe   <= 1'b1;
                        busOwn  <= 1'b1;
                        count   <= count + CNT_W'(1);
                        if (count == '0) begin
                            err_overflow <= 1'b0;
`ifdef LOADER_WDOG_EN
                            err_timeout  <= 1'b0;
`endif
                        end
                        if (finalByte) begin
                            in_ready <= 1'b0;
                            dataLen  <= 8'(count) + 8'd1;
                            if (!in_last) begin
                                err_overflow <= 1'b1;
                            end
                        end
                    end else if (!in_ready) begin
                        state    <= PAD;
                        padStart <= 1'b1;
                        busy     <= 1'b1;
`ifdef LOADER_WDOG_EN
                        wdogCnt  <= '0;
`endif
                    end
                end

                PAD: begin
                    if (padFinish) begin
                        state    <= HASH;
                        padStart <= 1'b0;
                        shaStart <= 1'b1;
`ifdef LOADER_WDOG_EN
                        wdogCnt  <= '0;
                    end else if (wdogExpired) begin
                        state       <= LOAD;
                        padStart    <= 1'b0;
                        err_timeout <= 1'b1;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        count       <= '0;
                    end else begin
                        wdogCnt <= wdogCnt + WD_W'(1);
`endif
                    end
                end

                HASH: begin
                    if (shaFinish) begin
                        state    <= DONE;
                        shaStart <= 1'b0;
                        done     <= 1'b1;
                        count    <= '0;
`ifdef LOADER_WDOG_EN
                    end else if (wdogExpired) begin
                        state       <= LOAD;
                        shaStart    <= 1'b0;
                        err_timeout <= 1'b1;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        count       <= '0;
                    end else begin
                        wdogCnt <= wdogCnt + WD_W'(1);
`endif
                    end
                end

                DONE: begin
                    state    <= LOAD;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    count    <= '0;
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_loader.sv
// ---------------------------------------------------------------------------
// tb_msg_loader
//
// Self-checking bench for msg_loader. Stimulus tasks push the expected RAM
// writes and completion results into queues; an independent monitor pops
// and compares them whenever the DUT strobes memWe or done.
// ---------------------------------------------------------------------------
module tb_msg_loader;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 55;
    localparam int BASE    = 0;
    localparam int WDOG    = 16;

    typedef logic [7:0] byteT;

    typedef struct {
        int   addr;
        byteT data;
    } wrT;

    typedef struct {
        int len;
        bit ovf;
    } doneT;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              memWe;
    logic              busOwn;
    logic [7:0]        dataLen;
    logic              padStart;
    logic              padFinish;
    logic              shaStart;
    logic              shaFinish;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic              err_timeout;

    wrT   expWrites[$];
    doneT expDone[$];
    int   testsRun  = 0;
    int   failures  = 0;
    int   doneSeen  = 0;

    msg_loader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_LEN    (MAX_LEN),
        .BASE_ADDR  (BASE),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .memAddr     (memAddr),
        .memData     (memData),
        .memWe       (memWe),
        .busOwn      (busOwn),
        .dataLen     (dataLen),
        .padStart    (padStart),
        .padFinish   (padFinish),
        .shaStart    (shaStart),
        .shaFinish   (shaFinish),
        .busy        (busy),
        .done        (done),
        .err_overflow(err_overflow),
        .err_timeout (err_timeout)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportMissing(input string name);
        testsRun++;
        failures++;
        $display("[TB] FAIL %s: DUT strobe with no expected entry queued", name);
    endtask

    // Monitor: compares every RAM write and every completion pulse against
    // the oldest entry the stimulus side queued.
    always @(negedge clk) begin
        if (!rst) begin
            if (memWe) begin
                if (expWrites.size() == 0) begin
                    reportMissing("unexpectedWrite");
                end else begin
                    wrT w;
                    w = expWrites.pop_front();
                    checkOutput("writeAddr", 32'(memAddr), 32'(w.addr));
                    checkOutput("writeData", 32'(memData), 32'(w.data));
                    checkOutput("writeBusOwn", 32'(busOwn), 32'd1);
                end
            end
            if (done) begin
                doneSeen++;
                if (expDone.size() == 0) begin
                    reportMissing("unexpectedDone");
                end else begin
                    doneT d;
                    d = expDone.pop_front();
                    checkOutput("doneDataLen", 32'(dataLen), 32'(d.len));
                    checkOutput("doneOverflow", 32'(err_overflow), 32'(d.ovf));
                    checkOutput("doneTimeout", 32'(err_timeout), 32'd0);
                end
            end
        end
    end

    // Reference model: the message ends at the first in_last inside the
    // first MAX_LEN bytes, otherwise it is truncated at MAX_LEN with the
    // overflow flag set. Each kept byte i lands at BASE+i.
    task automatic modelPush(input byteT msg[$], input int lastPos,
                             input bit expectDone, output int expLen);
        int L;
        bit ovf;
        if (lastPos >= 0 && lastPos < MAX_LEN) begin
            L   = lastPos + 1;
            ovf = 1'b0;
        end else begin
            L   = MAX_LEN;
            ovf = 1'b1;
        end
        for (int i = 0; i < L; i++) begin
            expWrites.push_back('{addr: BASE + i, data: msg[i]});
        end
        if (expectDone) begin
            expDone.push_back('{len: L, ovf: ovf});
        end
        expLen = L;
    endtask

    task automatic checkResetValues();
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstMemWe", 32'(memWe), 32'd0);
        checkOutput("rstBusOwn", 32'(busOwn), 32'd0);
        checkOutput("rstMemAddr", 32'(memAddr), 32'(BASE));
        checkOutput("rstMemData", 32'(memData), 32'd0);
        checkOutput("rstDataLen", 32'(dataLen), 32'd0);
        checkOutput("rstPadStart", 32'(padStart), 32'd0);
        checkOutput("rstShaStart", 32'(shaStart), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstOverflow", 32'(err_overflow), 32'd0);
        checkOutput("rstTimeout", 32'(err_timeout), 32'd0);
    endtask

    // Drives one message. validMode 0: continuous, 1: every other cycle,
    // 2: random. Returns at the negedge of the first PAD cycle, after
    // checking the LOAD->PAD timing and offering up to 8 surplus bytes that
    // must never be accepted.
    task automatic applyStimulus(input byteT msg[$], input int lastPos,
                                 input int validMode, input int expLen);
        int   idx    = 0;
        int   budget = 0;
        int   extras = 0;
        logic v;
        logic hs;
        while (idx < expLen) begin
            @(negedge clk);
            case (validMode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = msg[idx];
            in_last  = (idx == lastPos);
            hs       = v && in_ready;
            @(posedge clk);
            if (hs) idx++;
            budget++;
            if (budget > 1000) begin
                checkOutput("acceptTimeout", 32'(idx), 32'(expLen));
                break;
            end
        end

        @(negedge clk);
        if (idx < msg.size()) begin
            in_valid = 1'b1; in_data = msg[idx]; in_last = (idx == lastPos);
            idx++; extras++;
        end else begin
            in_valid = 1'b0; in_last = 1'b0;
        end
        checkOutput("readyDrop", 32'(in_ready), 32'd0);
        checkOutput("padNotYet", 32'(padStart), 32'd0);
        checkOutput("busyNotYet", 32'(busy), 32'd0);
        checkOutput("finalWriteStrobe", 32'(memWe), 32'd1);

        @(negedge clk);
        checkOutput("padStartRise", 32'(padStart), 32'd1);
        checkOutput("padBusy", 32'(busy), 32'd1);
        checkOutput("padBusOwn", 32'(busOwn), 32'd0);
        checkOutput("padDataLen", 32'(dataLen), 32'(expLen));
        if (idx < msg.size()) begin
            in_valid = 1'b1; in_data = msg[idx]; in_last = (idx == lastPos);
            idx++; extras++;
        end else begin
            in_valid = 1'b0; in_last = 1'b0;
        end
        while (idx < msg.size() && extras < 8) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = msg[idx]; in_last = (idx == lastPos);
            idx++; extras++;
        end
    endtask

    // Full message: stimulus, pad/sha handshakes with spurious finish
    // strobes in the wrong state, and completion timing.
    task automatic runMessage(input byteT msg[$], input int lastPos,
                              input int validMode, input int padDelay,
                              input int shaDelay);
        int L;
        int doneBefore;
        doneBefore = doneSeen;
        modelPush(msg, lastPos, 1'b1, L);
        applyStimulus(msg, lastPos, validMode, L);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < padDelay; c++) begin
            shaFinish = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput("padStartHeld", 32'(padStart), 32'd1);
        shaFinish = 1'b0;
        padFinish = 1'b1;
        @(negedge clk);
        padFinish = 1'b0;
        checkOutput("hashPadStart", 32'(padStart), 32'd0);
        checkOutput("hashShaStart", 32'(shaStart), 32'd1);
        for (int c = 0; c < shaDelay; c++) begin
            padFinish = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("shaStartHeld", 32'(shaStart), 32'd1);
        end
        padFinish = 1'b0;
        shaFinish = 1'b1;
        @(negedge clk);
        shaFinish = 1'b0;
        checkOutput("donePulse", 32'(done), 32'd1);
        checkOutput("doneShaStart", 32'(shaStart), 32'd0);
        @(negedge clk);
        checkOutput("doneOneCycle", 32'(done), 32'd0);
        checkOutput("readyReturn", 32'(in_ready), 32'd1);
        checkOutput("busyClear", 32'(busy), 32'd0);
        checkOutput("writesPending", 32'(expWrites.size()), 32'd0);
        checkOutput("doneCount", 32'(doneSeen), 32'(doneBefore + 1));
    endtask

    function automatic void buildRamp(output byteT msg[$], input int len,
                                      input int first);
        msg = {};
        for (int i = 0; i < len; i++) msg.push_back(byteT'(first + i));
    endfunction

    initial begin
        byteT msg[$];
        int   len;
        int   lastPos;
        int   dummyLen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        padFinish = 1'b0;
        shaFinish = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues();
        rst = 1'b0;

        buildRamp(msg, 30, 0);
        runMessage(msg, 29, 0, 3, 2);

        msg = {8'h61};
        runMessage(msg, 0, 0, 0, 0);
        checkOutput("singleOverflow", 32'(err_overflow), 32'd0);

        buildRamp(msg, 55, 8'h40);
        runMessage(msg, 54, 0, 1, 1);

        buildRamp(msg, 60, 8'h80);
        runMessage(msg, -1, 0, 2, 3);
        checkOutput("overflowSticky", 32'(err_overflow), 32'd1);

        buildRamp(msg, 30, 8'hA0);
        runMessage(msg, 29, 1, 2, 2);
        checkOutput("overflowCleared", 32'(err_overflow), 32'd0);

        // Reset while waiting in PAD abandons the message.
        buildRamp(msg, 6, 8'h10);
        modelPush(msg, 5, 1'b0, dummyLen);
        applyStimulus(msg, 5, 0, dummyLen);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkResetValues();
        rst = 1'b0;
        buildRamp(msg, 4, 8'hC4);
        runMessage(msg, 3, 0, 1, 1);

`ifdef LOADER_WDOG_EN
        begin
            int padCycles = 0;
            buildRamp(msg, 3, 8'h33);
            modelPush(msg, 2, 1'b0, dummyLen);
            applyStimulus(msg, 2, 0, dummyLen);
            in_valid = 1'b0;
            while (padStart && padCycles < 100) begin
                padCycles++;
                @(negedge clk);
            end
            checkOutput("wdogPadCycles", 32'(padCycles), 32'(WDOG));
            checkOutput("wdogTimeout", 32'(err_timeout), 32'd1);
            checkOutput("wdogReady", 32'(in_ready), 32'd1);
            checkOutput("wdogBusy", 32'(busy), 32'd0);
            buildRamp(msg, 5, 8'h50);
            runMessage(msg, 4, 0, 1, 1);
        end
`else
        buildRamp(msg, 8, 8'h70);
        runMessage(msg, 7, 0, 40, 40);
        checkOutput("noWdogTimeout", 32'(err_timeout), 32'd0);
`endif

        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(1, 64);
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(byteT'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) lastPos = -1;
            else lastPos = $urandom_range(0, len - 1);
            if (lastPos < 0 && len < MAX_LEN) lastPos = len - 1;
            runMessage(msg, lastPos, 2, $urandom_range(0, 5), $urandom_range(0, 5));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
